// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a framed byte stream, packs little-endian 32-bit words, drives the
// memory write port and holds the CPU in reset until a frame's checksum is good.
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes (LSB first), CSUM (XOR of data).
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   i_rx_valid/data    incoming byte; o_rx_ready accepts it (transfer on valid&ready)
//   o_mem_we/addr/wdata instruction memory write port (addr = word_index<<2)
//   o_cpu_hold         1 = keep CPU in reset
//   o_busy/done/err    frame in progress / last frame OK / last frame failed
//   o_words_loaded     words written in current/last frame
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter bit          BOOT_HOLD   = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_words_loaded
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   idx_q, idx_d;
  logic [23:0]   word_q, word_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   words_q, words_d;

  logic          fire;
  logic [15:0]   n_len;

  assign fire  = i_rx_valid & ready_q;
  assign n_len = {i_rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;
    ready_d = 1'b1;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (fire && (i_rx_data == SYNC_BYTE)) begin
          state_d = LEN0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          idx_d   = '0;
          csum_d  = '0;
          bcnt_d  = '0;
        end
      end
      LEN0: begin
        if (fire) begin
          len_d[7:0] = i_rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (fire) begin
          len_d = n_len;
          if (32'(n_len) > DEPTH_WORDS) begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (n_len == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (fire) begin
          csum_d = csum_q ^ i_rx_data;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = i_rx_data;
            2'd1: word_d[15:8]  = i_rx_data;
            2'd2: word_d[23:16] = i_rx_data;
            default: begin
              // Fourth byte goes straight to the write port; the WRITE
              // cycle then presents it with we=1.
              state_d = WRITE;
              we_d    = 1'b1;
              addr_d  = {14'b0, idx_q, 2'b00};
              wdata_d = {i_rx_data, word_q};
            end
          endcase
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        words_d = words_q + 16'd1;
        state_d = ((idx_q + 16'd1) == len_q) ? CSUM : DATA;
      end
      CSUM: begin
        if (fire) begin
          if (i_rx_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle-gap watchdog inside a frame; a received byte restarts the count.
    if ((state_q == LEN0 || state_q == LEN1 || state_q == DATA || state_q == CSUM) && !fire) begin
      tmo_d = tmo_q + TW'(1);
      if ((TIMEOUT_CYC != 0) && (32'(tmo_q) == TIMEOUT_CYC - 32'd1)) begin
        state_d = ERR;
        err_d   = 1'b1;
        hold_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    end

    ready_d = (state_d != WRITE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= BOOT_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign o_rx_ready     = ready_q;
  assign o_mem_we       = we_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_wdata    = wdata_q;
  assign o_cpu_hold     = hold_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames
// compared against a frame-level model (expected word list and final status).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [63:0] wq[$];

  imem_loader #(
    .DEPTH_WORDS(256),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(16),
    .BOOT_HOLD  (1'b1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_rx_ready    (rx_ready),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_cpu_hold    (cpu_hold),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Write-port monitor: records every write and checks ready is low exactly
  // while a write is presented.
  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    n_assert++;
    assert (rx_ready === ~mem_we) else begin
      n_fail++;
      $error("FAIL ready_vs_we: ready=%b we=%b required ready=~we", rx_ready, mem_we);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait_bound", (t < 20) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_hold, input logic e_busy, input logic [15:0] e_words);
    check({tag, "_done"},  done, e_done);
    check({tag, "_err"},   err, e_err);
    check({tag, "_hold"},  cpu_hold, e_hold);
    check({tag, "_busy"},  busy, e_busy);
    check({tag, "_words"}, words_loaded, e_words);
  endtask

  // Frame model: every complete group of four data bytes is one little-endian
  // word at byte address 4*k; the frame succeeds iff CSUM equals XOR of data.
  task automatic run_frame(input string tag, input logic [7:0] d[$], input logic [7:0] cx);
    logic [7:0]  cs = 8'h00;
    int unsigned n = d.size() / 4;
    logic [63:0] e;
    foreach (d[i]) cs ^= d[i];
    wq.delete();
    send_byte(8'hA5);
    check_status({tag, "_start"}, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (d[i]) send_byte(d[i]);
    send_byte(cs ^ cx);
    check({tag, "_nwrites"}, wq.size(), n);
    for (int unsigned k = 0; k < n && k < wq.size(); k++) begin
      e = {k * 32'd4, d[4*k+3], d[4*k+2], d[4*k+1], d[4*k]};
      check($sformatf("%s_w%0d_addr", tag, k), wq[k][63:32], e[63:32]);
      check($sformatf("%s_w%0d_data", tag, k), wq[k][31:0], e[31:0]);
    end
    if (cx == 8'h00) check_status({tag, "_end"}, 1'b1, 1'b0, 1'b0, 1'b0, n[15:0]);
    else             check_status({tag, "_end"}, 1'b0, 1'b1, 1'b1, 1'b0, n[15:0]);
  endtask

  initial begin
    logic [7:0] d[$];
    int unsigned n;
    logic [7:0] cx;

    // 1: reset values
    #12 rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", rx_ready, 1'b1);
    check("rst_we", mem_we, 1'b0);
    check_status("rst", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

    // 2: directed good frame
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame("good", d, 8'h00);

    // 3: same frame, checksum off by one bit, then a good frame
    run_frame("badcs", d, 8'h01);
    run_frame("recover", d, 8'h00);

    // 4: length over depth, then restart
    wq.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    check_status("len257", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    check("len257_nwrites", wq.size(), 0);
    run_frame("after257", d, 8'h00);

    // boundaries: N=0 and N=DEPTH_WORDS
    d.delete();
    run_frame("n0", d, 8'h00);
    for (int i = 0; i < 1024; i++) d.push_back(8'($urandom));
    run_frame("n256", d, 8'h00);

    // 5: timeout after 16 idle cycles inside a frame
    wq.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    repeat (15) begin @(posedge clk); #1; end
    check("tmo_15_err", err, 1'b0);
    check("tmo_15_busy", busy, 1'b1);
    @(posedge clk); #1;
    check_status("tmo_16", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    check("tmo_nwrites", wq.size(), 0);

    // 6: random back-to-back frames with dropped noise bytes between them
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 8'hA4)));
      check($sformatf("noise%0d_busy", f), busy, 1'b0);
      n = $urandom_range(1, 6);
      d.delete();
      for (int unsigned i = 0; i < 4 * n; i++)
        d.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
      cx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame($sformatf("rnd%0d", f), d, cx);
    end

    // reset pulse mid-DATA
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h55); send_byte(8'h66);
    check("mid_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("mrst_ready", rx_ready, 1'b1);
    check("mrst_we", mem_we, 1'b0);
    check("mrst_addr", mem_addr, 32'h0);
    check("mrst_wdata", mem_wdata, 32'h0);
    check_status("mrst", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("post_rst", d, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
